// File: rtl/proyecto_v2_fir_pkg.sv
// Shared constants, engine state encoding and the output saturation helper
// for the proyecto_v2 sixteen-tap FIR filter.
package proyecto_v2_fir_pkg;

    localparam int DATA_W     = 12;
    localparam int COEF_W     = 12;
    localparam int PROD_W     = 24;
    localparam int ACC_W      = 28;
    localparam int OUT_W      = 16;

    localparam int TAPS       = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int SHIFT      = 11;
    localparam int TAP_IDX_W  = $clog2(TAPS);

    // Engine state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] engState_t;
    localparam engState_t ENG_IDLE = 2'd0;
    localparam engState_t ENG_MAC  = 2'd1;
    localparam engState_t ENG_DONE = 2'd2;

    localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

    // Scales the Q1.11-weighted accumulator back to sample units (floor)
    // and clamps it into the 16-bit output range.
    function automatic logic signed [OUT_W-1:0] scaleAndSaturate(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] shifted;
        logic signed [ACC_W-1:0] maxExt;
        logic signed [ACC_W-1:0] minExt;
        shifted = acc >>> SHIFT;
        maxExt  = {{(ACC_W-OUT_W){SAT_MAX[OUT_W-1]}}, SAT_MAX};
        minExt  = {{(ACC_W-OUT_W){SAT_MIN[OUT_W-1]}}, SAT_MIN};
        if (shifted > maxExt) begin
            return SAT_MAX;
        end else if (shifted < minExt) begin
            return SAT_MIN;
        end else begin
            return shifted[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/proyecto_v2_fir_sync_fifo.sv
// Synchronous FIFO with registered full flag. Writes while full are dropped,
// pops while empty are ignored, and a push and pop on one edge both happen.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             doPush, doPop;

    assign doPush  = push_i & ~full_q;
    assign doPop   = pop_i & (count_q != '0);
    assign rdata_o = mem_q[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

    // Next pointers wrap explicitly so non-power-of-two depths also work
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Storage, pointers, occupancy and the full flag all move on one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= wdata_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: rtl/proyecto_v2_fir.sv
// Board-level top of proyecto_v2: sixteen-tap signed FIR filter with
// push-button coefficient loading, an input sample FIFO and a sequential
// multiply-accumulate engine that processes one sample every 18 cycles.
module proyecto_v2_fir
    import proyecto_v2_fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              pulsador_carga_coef_i,
    input  logic              send_i,
    input  logic              cambio_coef_i,
    output logic [OUT_W-1:0]  dato_out,
    output logic              led_full
);

    logic                        loadPrev_q, sendPrev_q, cambioPrev_q;
    logic                        loadRise, sendRise, cambioRise;

    logic                        loadMode_q, loadMode_d;
    logic [TAP_IDX_W-1:0]        coefIdx_q, coefIdx_d;
    logic [TAP_IDX_W-1:0]        wrIdx;
    logic                        coefWe;
    logic signed [COEF_W-1:0]    coef_q [TAPS];

    logic signed [DATA_W-1:0]    x_q [TAPS];
    logic signed [ACC_W-1:0]     acc_q;
    logic [TAP_IDX_W-1:0]        k_q;
    engState_t                   state_q;
    logic signed [OUT_W-1:0]     datoOut_q;
    logic signed [PROD_W-1:0]    product;

    logic                        popReq;
    logic [DATA_W-1:0]           fifoRdata;
    logic                        fifoFull, fifoEmpty;

    assign loadRise   = pulsador_carga_coef_i & ~loadPrev_q;
    assign sendRise   = send_i & ~sendPrev_q;
    assign cambioRise = cambio_coef_i & ~cambioPrev_q;

    assign popReq   = (state_q == ENG_IDLE) & ~fifoEmpty & ~loadMode_q;
    assign product  = x_q[k_q] * coef_q[k_q];
    assign dato_out = datoOut_q;
    assign led_full = fifoFull;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (sendRise),
        .pop_i   (popReq),
        .wdata_i (data_in),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Remember last sampled strobe levels so a held button acts only once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loadPrev_q   <= 1'b0;
            sendPrev_q   <= 1'b0;
            cambioPrev_q <= 1'b0;
        end else begin
            loadPrev_q   <= pulsador_carga_coef_i;
            sendPrev_q   <= send_i;
            cambioPrev_q <= cambio_coef_i;
        end
    end

    // Load-mode control: a load press restarts at slot 0 even on the same
    // edge as a write, and the write into the last slot leaves load mode
    always_comb begin
        loadMode_d = loadMode_q;
        coefIdx_d  = coefIdx_q;
        coefWe     = 1'b0;
        wrIdx      = loadRise ? '0 : coefIdx_q;
        if (loadRise) begin
            loadMode_d = 1'b1;
            coefIdx_d  = '0;
        end
        if (cambioRise && (loadMode_q || loadRise)) begin
            coefWe = 1'b1;
            if (wrIdx == TAP_IDX_W'(TAPS - 1)) begin
                loadMode_d = 1'b0;
                coefIdx_d  = '0;
            end else begin
                coefIdx_d = wrIdx + 1'b1;
            end
        end
    end

    // Load-mode flag, slot index and the coefficient RAM itself
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loadMode_q <= 1'b0;
            coefIdx_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            loadMode_q <= loadMode_d;
            coefIdx_q  <= coefIdx_d;
            if (coefWe) begin
                coef_q[wrIdx] <= coef_in;
            end
        end
    end

    // Engine: pop and shift in a sample, accumulate 16 products, then
    // publish the scaled and clamped result and return to idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ENG_IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            datoOut_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ENG_IDLE: begin
                    if (popReq) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            x_q[i] <= x_q[i-1];
                        end
                        x_q[0]  <= fifoRdata;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= ENG_MAC;
                    end
                end
                ENG_MAC: begin
                    acc_q <= acc_q + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
                    if (k_q == TAP_IDX_W'(TAPS - 1)) begin
                        state_q <= ENG_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ENG_DONE: begin
                    datoOut_q <= scaleAndSaturate(acc_q);
                    state_q   <= ENG_IDLE;
                end
                default: begin
                    state_q <= ENG_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proyecto_v2_fir.sv
// Directed testbench for proyecto_v2_fir: reset, impulse and step response,
// saturation, FIFO full/drop behaviour and reset during a computation.
module tb_proyecto_v2_fir;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] dataIn;
    logic [11:0] coefIn;
    logic        pulsador;
    logic        send;
    logic        cambio;
    logic [15:0] datoOut;
    logic        ledFull;

    int passCount  = 0;
    int checkCount = 0;

    int impCoef [16] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                         854, 376, -86, -156, 33, 136, 65, -99};
    int impResp [16] = '{99, -65, -136, -33, 156, 86, -376, -854,
                         -854, -376, 86, 156, -33, -136, -65, 99};

    always #5 clk = ~clk;

    proyecto_v2_fir dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_in               (dataIn),
        .coef_in               (coefIn),
        .pulsador_carga_coef_i (pulsador),
        .send_i                (send),
        .cambio_coef_i         (cambio),
        .dato_out              (datoOut),
        .led_full              (ledFull)
    );

    // One strobe cycle: a guaranteed low sample, then the requested strobes
    // high for exactly one edge. Returns 1 ns after that edge (E0).
    task automatic applyStimulus(input logic doLoad, input logic doCambio,
                                 input logic doSend, input int coefVal,
                                 input int dataVal);
        @(posedge clk);
        #1;
        coefIn   = 12'(coefVal);
        dataIn   = 12'(dataVal);
        pulsador = doLoad;
        cambio   = doCambio;
        send     = doSend;
        @(posedge clk);
        #1;
        pulsador = 1'b0;
        cambio   = 1'b0;
        send     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0d required %0d",
                    tag, $signed(observed), $signed(expected));
    endtask

    initial begin
        int prev;
        rst      = 1'b0;
        dataIn   = '0;
        coefIn   = '0;
        pulsador = 1'b0;
        send     = 1'b0;
        cambio   = 1'b0;

        // Reset held for 20 cycles
        repeat (20) @(posedge clk);
        #1;
        checkOutput("reset_dato_out", datoOut, 16'd0);
        checkOutput("reset_led_full", {15'd0, ledFull}, 16'd0);
        rst = 1'b1;

        // Impulse: load symmetric coefficients, first write with the load press
        $display("[TB] impulse response");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i == 0, 1'b1, 1'b0, impCoef[i], 0);
        end
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 0, (i == 0) ? -2048 : 0);
            repeat (17) @(posedge clk);
            #1;
            checkOutput($sformatf("impulse_hold_%0d", i), datoOut, 16'(prev));
            @(posedge clk);
            #1;
            checkOutput($sformatf("impulse_%0d", i), datoOut, 16'(impResp[i]));
            prev = impResp[i];
        end

        // Step: sixteen 1000s fill the delay line, sum(coef)=2246
        $display("[TB] step response");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 0, 1000);
        end
        repeat (16 * 18 + 20) @(posedge clk);
        #1;
        checkOutput("step_16th", datoOut, 16'd1096);

        // Saturation: all coefficients -1.0
        $display("[TB] saturation");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i == 0, 1'b1, 1'b0, -2048, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 0, -2048);
        repeat (18) @(posedge clk);
        #1;
        checkOutput("sat_first_mixed", datoOut, 16'(-12952));
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 0, -2048);
        end
        repeat (16 * 18 + 20) @(posedge clk);
        #1;
        checkOutput("sat_clamp", datoOut, 16'd32767);

        // FIFO full: park in load mode, push 17 samples (2,4,..,34)
        $display("[TB] fifo full");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 0, 2 * (i + 1));
            if (i >= 14) begin
                checkOutput($sformatf("led_full_push_%0d", i + 1),
                            {15'd0, ledFull}, (i >= 15) ? 16'd1 : 16'd0);
            end
        end
        // coef[0]=0.5, rest 0: each output is half the newest sample
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, (i == 0) ? 1024 : 0, 0);
        end
        checkOutput("led_full_before_pop", {15'd0, ledFull}, 16'd1);
        @(posedge clk);
        #1;
        checkOutput("led_full_after_pop", {15'd0, ledFull}, 16'd0);
        repeat (17) @(posedge clk);
        #1;
        checkOutput("fifo_out_1", datoOut, 16'd1);
        for (int j = 2; j <= 16; j++) begin
            repeat (18) @(posedge clk);
            #1;
            checkOutput($sformatf("fifo_out_%0d", j), datoOut, 16'(j));
        end
        repeat (40) @(posedge clk);
        #1;
        checkOutput("fifo_17th_dropped", datoOut, 16'd16);

        // Reset in the middle of MAC with more samples still queued
        $display("[TB] reset mid-MAC");
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 10);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 20);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 30);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midmac_reset_dato_out", datoOut, 16'd0);
        checkOutput("midmac_reset_led_full", {15'd0, ledFull}, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i == 0, 1'b1, 1'b0, (i == 0) ? 1024 : 0, 0);
        end
        repeat (60) @(posedge clk);
        #1;
        checkOutput("midmac_no_stale_output", datoOut, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 100);
        repeat (17) @(posedge clk);
        #1;
        checkOutput("post_reset_hold", datoOut, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("post_reset_out", datoOut, 16'd50);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
